// File: rtl/score_seg_scan.sv
// ---------------------------------------------------------------------------
// score_seg_scan
//   Converts a binary score to BCD with a serial double-dabble engine and
//   drives a multiplexed seven-segment display. A free-running prescaler
//   steps through the digits. The display supports leading-zero blanking,
//   whole-display blinking, and overflow saturation to all nines.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active high
//   i_score       binary score, captured when a load is accepted
//   i_load        one-cycle load request, ignored while busy
//   i_blank_lz    1 = blank leading zeros (digit 0 always shown)
//   i_blink       1 = flash the whole display from the blink counter MSB
//   o_busy        conversion in progress
//   o_overflow    last committed score did not fit in NUM_DIGITS digits
//   o_segment     {dp,g,f,e,d,c,b,a}, registered
//   o_segment_an  digit enables, bit 0 = least significant digit, registered
//
// Converter states
//   state | meaning
//   IDLE  | waiting for i_load; display register holds last result
//   CONV  | one double-dabble step per clock, SCORE_W steps in total
// ---------------------------------------------------------------------------
module score_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 10,
  parameter int SCAN_DIV   = 17,
  parameter int BLINK_DIV  = 25,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    i_score,
  input  logic                  i_load,
  input  logic                  i_blank_lz,
  input  logic                  i_blink,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic [7:0]            o_segment,
  output logic [NUM_DIGITS-1:0] o_segment_an
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;

  // Largest score that still fits in NUM_DIGITS decimal digits.
  function automatic logic [31:0] max_score(input int ndig);
    logic [31:0] v;
    v = 32'd1;
    for (int k = 0; k < ndig; k++) begin
      v = v * 32'd10;
    end
    return v - 32'd1;
  endfunction

  localparam logic [31:0] MAX_VAL = max_score(NUM_DIGITS);

  // Active-high {g,f,e,d,c,b,a}; non-decimal nibbles stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Converter registers
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCORE_W-1:0] shreg_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_pend_q;
  logic               busy_q;
  logic [BCD_W-1:0]   disp_q;
  logic               ovf_q;

  // Scan / blink registers
  logic [SCAN_DIV-1:0]   scan_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BLINK_DIV-1:0]  blink_q;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  // Next-state signals
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_d;
  logic [3:0]            cur_nib;
  logic                  lz_blank;
  logic                  blink_off;
  logic [7:0]            seg_ah;
  logic [NUM_DIGITS-1:0] an_ah;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // One double-dabble step: correct every nibble >= 5, then shift in the
  // next score bit (MSB first).
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end
    bcd_d = {bcd_adj[BCD_W-2:0], shreg_q[SCORE_W-1]};
  end

  // The overflow decision is made on the captured value so the scratch
  // register is free to wrap during an oversize conversion; its contents
  // are discarded in that case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bcd_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_load) begin
            shreg_q    <= i_score;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= ({{(32-SCORE_W){1'b0}}, i_score} > MAX_VAL);
            busy_q     <= 1'b1;
            state_q    <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= bcd_d;
          shreg_q <= {shreg_q[SCORE_W-2:0], 1'b0};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SCORE_W - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= ovf_pend_q;
            disp_q  <= ovf_pend_q ? {NUM_DIGITS{4'h9}} : bcd_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running prescaler and blink counter; the digit index steps when
  // the prescaler wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q  <= '0;
      idx_q   <= '0;
      blink_q <= '0;
    end else begin
      scan_q  <= scan_q + SCAN_DIV'(1);
      blink_q <= blink_q + BLINK_DIV'(1);
      if (&scan_q) begin
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Pattern for the current digit. A digit is a leading zero when it and
  // every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    cur_nib  = 4'd0;
    an_ah    = '0;
    lz_blank = i_blank_lz && (idx_q != '0);
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (IDX_W'(n) == idx_q) begin
        cur_nib  = disp_q[4*n +: 4];
        an_ah[n] = 1'b1;
      end
      if ((n >= int'(idx_q)) && (disp_q[4*n +: 4] != 4'd0)) begin
        lz_blank = 1'b0;
      end
    end
    blink_off = i_blink && blink_q[BLINK_DIV-1];
    seg_ah    = lz_blank ? 8'h00 : {1'b0, seg_decode(cur_nib)};
    if (lz_blank || blink_off) begin
      an_ah = '0;
    end
    seg_d = ACTIVE_LOW ? ~seg_ah : seg_ah;
    an_d  = ACTIVE_LOW ? ~an_ah : an_ah;
  end

  // Anode and pattern are registered together so a digit change never
  // shows one digit's pattern on another digit's anode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_overflow   = ovf_q;
  assign o_segment    = seg_q;
  assign o_segment_an = an_q;

endmodule

// File: tb/tb_score_seg_scan.sv
module tb_score_seg_scan;

  logic       clk;
  logic       rst;
  logic [9:0] score;
  logic       load4, load2, blank, blink;

  logic       busy4, ovf4;
  logic [7:0] seg4;
  logic [3:0] an4;
  logic       busy2, ovf2;
  logic [7:0] seg2;
  logic [1:0] an2;

  logic       sel;
  logic       busy_s, ovf_s;
  logic [7:0] seg_s;
  logic [3:0] an_s;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc;

  typedef struct {
    int              blen;
    logic            ovf;
    logic [3:0][7:0] seg;
    logic [3:0]      vis;
  } exp_t;

  exp_t exp_q[$];

  score_seg_scan #(
    .NUM_DIGITS(4), .SCORE_W(10), .SCAN_DIV(2), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)
  ) dut4 (
    .clk(clk), .rst(rst), .i_score(score), .i_load(load4),
    .i_blank_lz(blank), .i_blink(blink), .o_busy(busy4),
    .o_overflow(ovf4), .o_segment(seg4), .o_segment_an(an4)
  );

  score_seg_scan #(
    .NUM_DIGITS(2), .SCORE_W(10), .SCAN_DIV(2), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .i_score(score), .i_load(load2),
    .i_blank_lz(blank), .i_blink(blink), .o_busy(busy2),
    .o_overflow(ovf2), .o_segment(seg2), .o_segment_an(an2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    busy_s = sel ? busy2 : busy4;
    ovf_s  = sel ? ovf2 : ovf4;
    seg_s  = sel ? seg2 : seg4;
    an_s   = sel ? {2'b11, an2} : an4;
  end

  // Clocks since reset release: reference for scan/blink timing.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Watch 16 cycles of scan output; record each digit's pattern.
  task automatic observe(output logic [3:0][7:0] segs, output logic [3:0] seen,
                         output int offc, output int bad);
    logic [3:0] m;
    bit found;
    segs = '0; seen = '0; offc = 0; bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (an_s == 4'hF) begin
        offc++;
        if (seg_s !== 8'hFF) bad++;
      end else begin
        found = 1'b0;
        for (int d = 0; d < 4; d++) begin
          m = 4'b0001 << d;
          if (an_s == ~m) begin
            seen[d] = 1'b1;
            segs[d] = seg_s;
            found   = 1'b1;
          end
        end
        if (!found) bad++;
      end
    end
  endtask

  task automatic push(input int blen, input logic ovf, input logic [3:0][7:0] seg,
                      input logic [3:0] vis);
    exp_t e;
    e.blen = blen; e.ovf = ovf; e.seg = seg; e.vis = vis;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    score = 10'(v);
    if (sel) load2 = 1'b1; else load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    load2 = 1'b0;
  endtask

  task automatic wait_mon(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < target) chk("monitor_timeout", 32'(done_cnt), 32'(target));
  endtask

  // Monitor: each completed conversion pops one expectation.
  initial begin : monitor
    exp_t e;
    int blen, offc, bad, nvis, nd;
    logic [3:0][7:0] segs;
    logic [3:0] seen;
    forever begin
      @(negedge clk);
      if (busy_s === 1'b1) begin
        blen = 0;
        while (busy_s === 1'b1 && blen < 64) begin
          blen++;
          @(negedge clk);
        end
        if (rst === 1'b1) continue;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_conv actual=busy_pulse expected=none");
        end else begin
          e = exp_q.pop_front();
          nd = sel ? 2 : 4;
          chk("busy_len", 32'(blen), 32'(e.blen));
          chk("overflow", {31'd0, ovf_s}, {31'd0, e.ovf});
          @(negedge clk);
          observe(segs, seen, offc, bad);
          chk("scan_bad", 32'(bad), 32'd0);
          nvis = 0;
          for (int d = 0; d < nd; d++) begin
            if (e.vis[d]) begin
              nvis++;
              chk($sformatf("seen_d%0d", d), {31'd0, seen[d]}, 32'd1);
              chk($sformatf("seg_d%0d", d), {24'd0, segs[d]}, {24'd0, e.seg[d]});
            end else begin
              chk($sformatf("blank_d%0d", d), {31'd0, seen[d]}, 32'd0);
            end
          end
          chk("off_cycles", 32'(offc), 32'((16 / nd) * (nd - nvis)));
        end
        done_cnt++;
      end
    end
  end

  initial begin : stim
    logic [3:0][7:0] segs;
    logic [3:0] seen, m, exp_an;
    int offc, bad, k, n;
    rst = 1'b0; sel = 1'b0; score = '0;
    load4 = 1'b0; load2 = 1'b0; blank = 1'b0; blink = 1'b0;
    #1 rst = 1'b1;
    #3;
    chk("rst_an", {28'd0, an4}, 32'hF);
    chk("rst_seg", {24'd0, seg4}, 32'hFF);
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_ovf", {31'd0, ovf4}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", {28'd0, an4}, 32'hE);
    chk("first_seg", {24'd0, seg4}, 32'hC0);

    // 1023 -> 1,0,2,3
    push(10, 1'b0, {8'hF9, 8'hC0, 8'hA4, 8'hB0}, 4'hF);
    do_load(1023); wait_mon(1);

    // 7 with and without leading-zero blanking
    blank = 1'b1;
    push(10, 1'b0, {8'h00, 8'h00, 8'h00, 8'hF8}, 4'b0001);
    do_load(7); wait_mon(2);
    blank = 1'b0;
    push(10, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hF8}, 4'hF);
    do_load(7); wait_mon(3);

    // Zero with blanking shows a single 0
    blank = 1'b1;
    push(10, 1'b0, {8'h00, 8'h00, 8'h00, 8'hC0}, 4'b0001);
    do_load(0); wait_mon(4);
    blank = 1'b0;

    // Load during conversion is ignored
    push(10, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'h92}, 4'hF);
    do_load(5);
    repeat (2) @(negedge clk);
    score = 10'd900; load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    wait_mon(5);

    // Two-digit instance: overflow then recovery
    sel = 1'b1;
    push(10, 1'b1, {8'h00, 8'h00, 8'h90, 8'h90}, 4'b0011);
    do_load(150); wait_mon(6);
    push(10, 1'b0, {8'h00, 8'h00, 8'h99, 8'hA4}, 4'b0011);
    do_load(42); wait_mon(7);
    sel = 1'b0;

    // Reset in the middle of a conversion
    push(10, 1'b0, {8'hC0, 8'hB0, 8'hA4, 8'hF9}, 4'hF);
    do_load(321); wait_mon(8);
    do_load(500);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_an", {28'd0, an4}, 32'hF);
    chk("midrst_seg", {24'd0, seg4}, 32'hFF);
    chk("midrst_busy", {31'd0, busy4}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", {28'd0, an4}, 32'hE);
    chk("post_rst_seg", {24'd0, seg4}, 32'hC0);
    chk("post_rst_busy", {31'd0, busy4}, 32'd0);
    observe(segs, seen, offc, bad);
    chk("post_rst_seen", {28'd0, seen}, 32'hF);
    chk("post_rst_segs", segs, 32'hC0C0C0C0);
    chk("post_rst_off", 32'(offc), 32'd0);

    // Scan order with blink off, then blink on
    for (int pass = 0; pass < 2; pass++) begin
      blink = (pass == 1);
      @(negedge clk);
      bad = 0; n = 0;
      repeat (32) begin
        @(negedge clk);
        k = cyc - 1;
        m = 4'b0001 << ((k / 4) % 4);
        exp_an = (blink && (k % 16) >= 8) ? 4'hF : ~m;
        if (an4 !== exp_an) bad++;
        if (an4 == 4'hF) n++;
      end
      chk($sformatf("scan_seq_blink%0d", pass), 32'(bad), 32'd0);
      chk($sformatf("off_cnt_blink%0d", pass), 32'(n), (pass == 1) ? 32'd16 : 32'd0);
    end
    blink = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
